// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults and sequencer state type for the serial-load SRAM path
package sram_pkg;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_ADDR_WIDTH = 4;
  localparam int SRAM_RD_TIMEOUT = 16;
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP} sram_seq_state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_piso.sv
// sram_piso: parallel-load MSB-first shift register; drains to zero so serial_out idles low
module sram_piso
  import sram_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] data,
  output logic             last_bit,
  output logic             serial_out
);
  localparam int CW = cnt_width(WIDTH);
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  // load a word, then shift left one bit per advance while counting bits
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
    end else if (advance) begin
      sreg <= sreg << 1;
      cnt  <= last_bit ? '0 : cnt + CW'(1);
    end
  assign last_bit   = cnt == CW'(WIDTH - 1);
  assign serial_out = sreg[WIDTH-1];
endmodule

// File: rtl/sram_cmd_sequencer.sv
// sram_cmd_sequencer: turns host read/write requests into sram_top pin sequences
module sram_cmd_sequencer
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int RD_TIMEOUT = SRAM_RD_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  serial_in,
  output logic                  shift,
  output logic                  w_en,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_out
);
  localparam int TW = cnt_width(RD_TIMEOUT + 1);
  sram_seq_state_t state;
  logic [TW-1:0]   tcnt;
  logic            last_bit;
  logic            accept;
  assign accept = req_valid & req_ready;
  sram_piso #(.WIDTH(DATA_WIDTH)) u_piso (
    .clk       (clk),
    .arst      (arst),
    .load      (accept & req_write),
    .advance   (state == SHIFT),
    .data      (req_wdata),
    .last_bit  (last_bit),
    .serial_out(serial_in)
  );
  // request FSM with registered strobes; addr register doubles as the request address latch
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state     <= IDLE;
      tcnt      <= '0;
      req_ready <= 1'b1;
      shift     <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            state     <= req_write ? SHIFT : READ;
            req_ready <= 1'b0;
            addr      <= req_addr;
            shift     <= req_write;
            r_en      <= !req_write;
          end
        SHIFT:
          if (last_bit) begin
            state <= WRITE;
            shift <= 1'b0;
            w_en  <= 1'b1;
          end
        WRITE: begin
          state     <= RESP;
          w_en      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
        end
        READ: begin
          r_en  <= 1'b0;
          tcnt  <= '0;
          state <= data_valid ? RESP : WAIT_RD;
          if (data_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= data_out;
            rsp_err   <= 1'b0;
          end
        end
        WAIT_RD:
          if (data_valid || tcnt == TW'(RD_TIMEOUT)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= data_valid ? data_out : '0;
            rsp_err   <= !data_valid;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          addr      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// tb_sram_cmd_sequencer: table, directed and random checks against a behavioural SRAM model
module tb_sram_cmd_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic data_valid = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic req_ready, rsp_valid, rsp_err, serial_in, shift, w_en, r_en;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] addr;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] sh = '0;
  int rd_left = -1;
  int rd_lat = 0;
  bit noise_en = 0;
  bit force_dv = 0;
  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lat;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;
  always #5 clk = ~clk;
  sram_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .serial_in(serial_in), .shift(shift), .w_en(w_en), .r_en(r_en), .addr(addr),
    .data_valid(data_valid), .data_out(data_out)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one clock, then play the SRAM macro: collect serial bits, store on w_en, answer r_en after rd_lat cycles
  task automatic cycle();
    @(posedge clk);
    #1;
    if (shift) sh = {sh[DW-2:0], serial_in};
    if (w_en) mem[addr] = sh;
    if (r_en) rd_left = rd_lat;
    if (rsp_valid) rd_left = -1;
    data_out = DW'($urandom);
    if (rd_left == 0) begin
      data_valid = 1'b1;
      data_out = mem[addr];
      rd_left = -1;
    end else begin
      if (rd_left > 0) rd_left--;
      data_valid = force_dv || (noise_en && rd_left < 0 && $urandom_range(0, 1) == 1);
    end
  endtask
  task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat,
                        input bit hold, input logic [DW-1:0] exp_d, input bit exp_e, input string nm);
    int k, exp_k, wcyc, rcyc;
    logic [31:0] shmask;
    logic [DW-1:0] bits;
    bit addr_ok, excl_ok, busy_ok;
    rd_lat = lat;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 50) begin
      cycle();
      k++;
    end
    cycle();
    req_valid = hold;
    req_write = 1'($urandom);
    req_addr = AW'($urandom);
    req_wdata = DW'($urandom);
    if (w) ref_mem[a] = d;
    exp_k = w ? DW + 2 : (lat <= TO + 1 ? lat + 2 : TO + 3);
    shmask = '0;
    bits = '0;
    wcyc = 0;
    rcyc = 0;
    addr_ok = 1;
    excl_ok = 1;
    busy_ok = 1;
    for (k = 1; k <= TO + 10; k++) begin
      if (shift) begin
        shmask[k] = 1'b1;
        bits = {bits[DW-2:0], serial_in};
      end
      if (w_en) wcyc = k;
      if (r_en) rcyc = k;
      if (addr !== a) addr_ok = 0;
      if (int'(shift) + int'(w_en) + int'(r_en) > 1) excl_ok = 0;
      if (req_ready !== 1'b0) busy_ok = 0;
      if (rsp_valid) break;
      cycle();
    end
    chk({nm, "_rsp_cycle"}, k, exp_k);
    chk({nm, "_rsp_data"}, rsp_data, exp_d);
    chk({nm, "_rsp_err"}, rsp_err, exp_e);
    chk({nm, "_shift_cycles"}, shmask, w ? 32'h1FE : 32'h0);
    if (w) begin
      chk({nm, "_serial_bits"}, bits, d);
      chk({nm, "_wen_cycle"}, wcyc, DW + 1);
    end else begin
      chk({nm, "_ren_cycle"}, rcyc, 1);
    end
    chk({nm, "_addr_held"}, addr_ok, 1);
    chk({nm, "_strobe_excl"}, excl_ok, 1);
    chk({nm, "_busy"}, busy_ok, 1);
    if (k <= TO + 10) begin
      cycle();
      chk({nm, "_ready_after"}, req_ready, 1);
      chk({nm, "_addr_idle"}, addr, 0);
      chk({nm, "_rsp_pulse"}, rsp_valid, 0);
    end
  endtask
  initial begin
    vec_t tbl [8];
    int n;
    bit w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int lat;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    tbl[0] = '{1, 4'h3, 8'hA5, 0, 8'h00, 0};
    tbl[1] = '{0, 4'h3, 8'h00, 0, 8'hA5, 0};
    tbl[2] = '{0, 4'h3, 8'h00, 4, 8'hA5, 0};
    tbl[3] = '{0, 4'h3, 8'h00, 18, 8'h00, 1};
    tbl[4] = '{0, 4'h3, 8'h00, 17, 8'hA5, 0};
    tbl[5] = '{1, 4'h9, 8'h3C, 0, 8'h00, 0};
    tbl[6] = '{0, 4'h9, 8'h00, 1, 8'h3C, 0};
    tbl[7] = '{0, 4'h5, 8'h00, 30, 8'h00, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {rsp_valid, rsp_err, serial_in, shift, w_en, r_en}, 0);
    chk("reset_ready", req_ready, 1);
    arst = 1'b0;
    cycle();
    chk("reset_addr", addr, 0);
    chk("reset_rsp_data", rsp_data, 0);
    for (int i = 0; i < 8; i++)
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat, 0, tbl[i].exp_data, tbl[i].exp_err,
             $sformatf("tbl%0d", i));
    do_req(1, 4'hF, 8'hFF, 0, 1, 8'h00, 0, "b2b_wr_ff");
    do_req(1, 4'h0, 8'h00, 0, 1, 8'h00, 0, "b2b_wr_00");
    do_req(0, 4'hF, 8'h00, 2, 1, 8'hFF, 0, "b2b_rd_ff");
    do_req(0, 4'h0, 8'h00, 0, 1, 8'h00, 0, "b2b_rd_00");
    req_valid = 1'b0;
    force_dv = 1;
    cycle();
    cycle();
    force_dv = 0;
    n = 0;
    repeat (6) begin
      cycle();
      n += int'(rsp_valid);
    end
    chk("stray_dv_no_rsp", n, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 4'h3;
    req_wdata = 8'h5A;
    cycle();
    req_valid = 1'b0;
    repeat (3) cycle();
    chk("rst_mid_shift", shift, 1);
    #2 arst = 1'b1;
    #1;
    chk("rst_async_outputs", {rsp_valid, rsp_err, serial_in, shift, w_en, r_en}, 0);
    chk("rst_async_addr", addr, 0);
    chk("rst_async_data", rsp_data, 0);
    rd_left = -1;
    repeat (2) cycle();
    arst = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);
    n = 0;
    repeat (15) begin
      cycle();
      n += int'(rsp_valid) + int'(w_en);
    end
    chk("rst_dropped", n, 0);
    do_req(0, 4'h3, 8'h00, 0, 0, 8'hA5, 0, "rst_mem_intact");
    noise_en = 1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = AW'($urandom);
      d = DW'($urandom);
      lat = $urandom_range(0, 22);
      if (w) do_req(1, a, d, lat, 1'($urandom), 8'h00, 0, $sformatf("rnd%0d_wr", i));
      else if (lat <= TO + 1) do_req(0, a, d, lat, 1'($urandom), ref_mem[a], 0, $sformatf("rnd%0d_rd", i));
      else do_req(0, a, d, lat, 1'($urandom), 8'h00, 1, $sformatf("rnd%0d_to", i));
    end
    req_valid = 1'b0;
    noise_en = 0;
    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
